// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge: host valid/ready requests to APB4 master transfers,
// with an optional ACCESS-phase watchdog that aborts hung transfers.
module rggen_apb_bridge #(
   parameter int ADDRESS_WIDTH  = 8,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_valid,
   input  logic [ADDRESS_WIDTH-1:0] i_address,
   input  logic                     i_write,
   input  logic [BUS_WIDTH-1:0]     i_write_data,
   input  logic [BUS_WIDTH/8-1:0]   i_strobe,
   output logic                     o_ready,
   output logic [1:0]               o_status,
   output logic [BUS_WIDTH-1:0]     o_read_data,
   output logic                     o_psel,
   output logic                     o_penable,
   output logic [ADDRESS_WIDTH-1:0] o_paddr,
   output logic                     o_pwrite,
   output logic [BUS_WIDTH-1:0]     o_pwdata,
   output logic [BUS_WIDTH/8-1:0]   o_pstrb,
   input  logic                     i_pready,
   input  logic [BUS_WIDTH-1:0]     i_prdata,
   input  logic                     i_pslverr
);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_t;
   state_t state, state_next;
   logic [CW-1:0] count;
   logic timeout, done;
   // a real pready on the last allowed edge takes priority over the abort
   always_comb begin
      timeout = (TIMEOUT_CYCLES > 0) && (state == ACCESS) && !i_pready && (count == CW'(TIMEOUT_CYCLES - 1));
      done = (state == ACCESS) && (i_pready || timeout);
      state_next = state;
      case (state)
         IDLE:    state_next = i_valid ? SETUP : IDLE;
         SETUP:   state_next = ACCESS;
         ACCESS:  state_next = done ? RESPONSE : ACCESS;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else state <= state_next;
   end
   // outputs are flopped from the next state so nothing is combinational to the pins
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_psel      <= 1'b0;
         o_penable   <= 1'b0;
         o_ready     <= 1'b0;
         o_paddr     <= '0;
         o_pwrite    <= 1'b0;
         o_pwdata    <= '0;
         o_pstrb     <= '0;
         o_status    <= 2'b00;
         o_read_data <= '0;
         count       <= '0;
      end else begin
         o_psel    <= (state_next == SETUP) || (state_next == ACCESS);
         o_penable <= state_next == ACCESS;
         o_ready   <= state_next == RESPONSE;
         count     <= (state == ACCESS && !i_pready) ? count + 1'b1 : '0;
         if (state == IDLE && i_valid) begin
            o_paddr  <= i_address;
            o_pwrite <= i_write;
            o_pwdata <= i_write ? i_write_data : '0;
            o_pstrb  <= i_write ? i_strobe : '0;
         end
         if (done) begin
            o_status    <= i_pready ? {i_pslverr, 1'b0} : 2'b11;
            o_read_data <= (i_pready && !o_pwrite) ? i_prdata : '0;
         end
      end
   end
endmodule
